// File: rtl/spdif_transmit.sv
// S/PDIF transmitter: biphase-mark encoded stereo frames with B/M/W preambles and 192-frame blocks.
// Define SPDIF_CHANNEL_STATUS_EN to send consumer channel status (copy permitted, sample-rate code).
module spdif_transmit #(
    parameter int SPDIF_BAUD = 12_288_000,
    parameter int CLK_FREQ   = 24_576_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_left,
    input  logic [31:0] data_right,
    input  logic        validity,
    input  logic [3:0]  sample_rate_code,
    output logic        spdif_out
);

    localparam int HALF = CLK_FREQ / (2 * SPDIF_BAUD);
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;

    logic [DIV_W-1:0] div_q, div_d;
    logic [5:0]       hcell_q, hcell_d;
    logic             right_q, right_d;
    logic [7:0]       frame_q, frame_d;
    logic [23:0]      left_cap_q, left_cap_d;
    logic [23:0]      right_cap_q, right_cap_d;
    logic             valid_cap_q, valid_cap_d;
    logic             pre_inv_q, pre_inv_d;
    logic             out_q, out_d;

    logic             half_start;
    logic             half_end;
    logic [23:0]      audio_word;
    logic [4:0]       slot;
    logic [4:0]       audio_idx;
    logic             cs_bit;
    logic             parity_bit;
    logic             slot_bit;
    logic [7:0]       pre_pat;
    logic             pre_inv;
    logic             line_level;

    // Low audio bytes are never transmitted.
    logic unused_low_bytes;
    assign unused_low_bytes = ^{data_left[7:0], data_right[7:0]};

`ifdef SPDIF_CHANNEL_STATUS_EN
    logic [3:0] rate_cap_q, rate_cap_d;

    always_comb begin
        rate_cap_d = rate_cap_q;
        if (half_start && hcell_q == 6'd0 && !right_q) begin
            rate_cap_d = sample_rate_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate_cap_q <= '0;
        end else begin
            rate_cap_q <= rate_cap_d;
        end
    end

    // Frame number selects the channel-status bit of the block.
    always_comb begin
        cs_bit = 1'b0;
        case (frame_q)
            8'd2:    cs_bit = 1'b1;
            8'd24:   cs_bit = rate_cap_q[0];
            8'd25:   cs_bit = rate_cap_q[1];
            8'd26:   cs_bit = rate_cap_q[2];
            8'd27:   cs_bit = rate_cap_q[3];
            default: cs_bit = 1'b0;
        endcase
    end
`else
    logic unused_rate;
    assign unused_rate = ^sample_rate_code;
    assign cs_bit = 1'b0;
`endif

    assign half_start = (div_q == '0);
    assign half_end   = (div_q == DIV_LAST);
    assign audio_word = right_q ? right_cap_q : left_cap_q;
    assign slot       = hcell_q[5:1];
    assign audio_idx  = slot - 5'd4;
    assign parity_bit = ^{audio_word, valid_cap_q, 1'b0, cs_bit};

    always_comb begin
        slot_bit = 1'b0;
        case (slot)
            5'd28:   slot_bit = valid_cap_q;
            5'd29:   slot_bit = 1'b0;
            5'd30:   slot_bit = cs_bit;
            5'd31:   slot_bit = parity_bit;
            default: begin
                if (slot >= 5'd4) begin
                    slot_bit = audio_word[audio_idx];
                end
            end
        endcase
    end

    // Preamble polarity follows the line level just before the first preamble half-cell.
    always_comb begin
        pre_pat = PRE_W;
        if (!right_q) begin
            pre_pat = (frame_q == 8'd0) ? PRE_B : PRE_M;
        end
        pre_inv = (hcell_q == 6'd0) ? out_q : pre_inv_q;
        line_level = out_q;
        if (hcell_q < 6'd8) begin
            line_level = pre_pat[3'd7 - hcell_q[2:0]] ^ pre_inv;
        end else if (!hcell_q[0]) begin
            line_level = ~out_q;
        end else begin
            line_level = slot_bit ? ~out_q : out_q;
        end
    end

    always_comb begin
        div_d       = div_q;
        hcell_d     = hcell_q;
        right_d     = right_q;
        frame_d     = frame_q;
        left_cap_d  = left_cap_q;
        right_cap_d = right_cap_q;
        valid_cap_d = valid_cap_q;
        pre_inv_d   = pre_inv_q;
        out_d       = out_q;

        if (half_end) begin
            div_d   = '0;
            hcell_d = hcell_q + 6'd1;
            if (hcell_q == 6'd63) begin
                right_d = ~right_q;
                if (right_q) begin
                    frame_d = (frame_q == 8'd191) ? 8'd0 : frame_q + 8'd1;
                end
            end
        end else begin
            div_d = div_q + DIV_ONE;
        end

        // Inputs are sampled once per frame, on the first clock of the left subframe.
        if (half_start) begin
            out_d = line_level;
            if (hcell_q == 6'd0) begin
                pre_inv_d = out_q;
                if (!right_q) begin
                    left_cap_d  = data_left[31:8];
                    right_cap_d = data_right[31:8];
                    valid_cap_d = validity;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            hcell_q     <= '0;
            right_q     <= 1'b0;
            frame_q     <= '0;
            left_cap_q  <= '0;
            right_cap_q <= '0;
            valid_cap_q <= 1'b0;
            pre_inv_q   <= 1'b0;
            out_q       <= 1'b0;
        end else begin
            div_q       <= div_d;
            hcell_q     <= hcell_d;
            right_q     <= right_d;
            frame_q     <= frame_d;
            left_cap_q  <= left_cap_d;
            right_cap_q <= right_cap_d;
            valid_cap_q <= valid_cap_d;
            pre_inv_q   <= pre_inv_d;
            out_q       <= out_d;
        end
    end

    assign spdif_out = out_q;

endmodule

// File: tb/tb_spdif_transmit.sv
// Testbench for spdif_transmit: decodes the biphase-mark line per subframe and
// compares against a scoreboard of expected subframes pushed when inputs are driven.
module tb_spdif_transmit;

    typedef struct packed {
        logic [7:0]  pre;
        logic [23:0] aud;
        logic        v;
        logic        u;
        logic        c;
        logic        par_ok;
        logic        bmc_ok;
    } sub_t;

    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_left = '0;
    logic [31:0] data_right = '0;
    logic        validity = 1'b0;
    logic [3:0]  sample_rate_code = 4'b1100;
    logic        spdif_out;

    int checks = 0;
    int errors = 0;

    sub_t sb[$];
    int   sb_frame = 0;
    int   rx_frame = 0;
    logic [191:0] cs_left = '0;
    logic [191:0] cs_right = '0;

    spdif_transmit #(.SPDIF_BAUD(12_288_000), .CLK_FREQ(24_576_000)) dut (
        .clk(clk),
        .rst(rst),
        .data_left(data_left),
        .data_right(data_right),
        .validity(validity),
        .sample_rate_code(sample_rate_code),
        .spdif_out(spdif_out)
    );

    always #5 clk = ~clk;

    function automatic logic cs_exp(input int n, input logic [3:0] code);
        logic r;
        r = 1'b0;
`ifdef SPDIF_CHANNEL_STATUS_EN
        if (n == 2) r = 1'b1;
        if (n >= 24 && n <= 27) r = code[n - 24];
`endif
        return r;
    endfunction

    // Expected subframes for the frame that will capture the current inputs.
    task automatic push_frame();
        sub_t e;
        e.pre    = (sb_frame == 0) ? PRE_B : PRE_M;
        e.aud    = data_left[31:8];
        e.v      = validity;
        e.u      = 1'b0;
        e.c      = cs_exp(sb_frame, sample_rate_code);
        e.par_ok = 1'b1;
        e.bmc_ok = 1'b1;
        sb.push_back(e);
        e.pre = PRE_W;
        e.aud = data_right[31:8];
        sb.push_back(e);
        sb_frame = (sb_frame + 1) % 192;
    endtask

    // Samples 64 half-cells and decodes them; no comparisons here.
    task automatic receive_subframe(input bit is_right, output sub_t obs);
        logic        hc [64];
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            hc[i] = spdif_out;
        end
        for (int i = 0; i < 8; i++) obs.pre[7 - i] = hc[i];
        obs.bmc_ok = 1'b1;
        for (int k = 4; k < 32; k++) begin
            b[k] = hc[2 * k] ^ hc[2 * k + 1];
            if (hc[2 * k] == hc[2 * k - 1]) obs.bmc_ok = 1'b0;
        end
        obs.aud    = b[27:4];
        obs.v      = b[28];
        obs.u      = b[29];
        obs.c      = b[30];
        obs.par_ok = ~^b[31:4];
        if (is_right) begin
            cs_right[rx_frame] = obs.c;
            rx_frame = (rx_frame + 1) % 192;
        end else begin
            cs_left[rx_frame] = obs.c;
        end
    endtask

    task automatic pop_exp(output sub_t e);
        if (sb.size() == 0) begin
            $display("[TB] FAIL scoreboard_empty: got 0 entries required 1");
            errors++;
            e = '0;
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        sub_t obs, exp;
        rst = 1'b1;
        data_left = 32'h123456AB;
        data_right = 32'hFEDCBA00;
        validity = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (spdif_out !== 1'b0) begin
                $display("[TB] FAIL reset_low: got %b required 0 (clock %0d)", spdif_out, i);
                errors++;
            end
        end
        sb_frame = 0;
        rx_frame = 0;
        push_frame();
        rst = 1'b0;
        receive_subframe(1'b0, obs);
        pop_exp(exp);
        checks++;
        if (obs.pre !== 8'b11101000) begin
            $display("[TB] FAIL first_preamble: got %b required 11101000", obs.pre);
            errors++;
        end
        checks++;
        if (obs !== exp) begin
            $display("[TB] FAIL reset_frame0_left: got %h required %h", obs, exp);
            errors++;
        end
    endtask

    task automatic test_audio();
        sub_t obs, exp;
        receive_subframe(1'b1, obs);
        pop_exp(exp);
        checks++;
        if (obs.aud !== 24'hFEDCBA || obs !== exp) begin
            $display("[TB] FAIL audio_frame0_right: got %h required %h", obs, exp);
            errors++;
        end
        data_left = 32'h00000001;
        data_right = 32'hFFFFFF55;
        push_frame();
        for (int s = 0; s < 2; s++) begin
            receive_subframe(s[0], obs);
            pop_exp(exp);
            checks++;
            if (obs !== exp) begin
                $display("[TB] FAIL audio_frame1_sub%0d: got %h required %h", s, obs, exp);
                errors++;
            end
        end
    endtask

    task automatic test_frame_hold();
        sub_t obs, exp;
        data_left = 32'hA5A5A500;
        data_right = 32'h5A5A5A00;
        validity = 1'b0;
        push_frame();
        receive_subframe(1'b0, obs);
        pop_exp(exp);
        checks++;
        if (obs !== exp) begin
            $display("[TB] FAIL hold_left: got %h required %h", obs, exp);
            errors++;
        end
        data_right = 32'h0F0F0F00;
        validity = 1'b1;
        receive_subframe(1'b1, obs);
        pop_exp(exp);
        checks++;
        if (obs !== exp) begin
            $display("[TB] FAIL hold_right: got %h required %h", obs, exp);
            errors++;
        end
    endtask

    task automatic test_validity();
        sub_t obs, exp;
        for (int f = 0; f < 2; f++) begin
            data_left = $urandom;
            data_right = $urandom;
            push_frame();
            for (int s = 0; s < 2; s++) begin
                receive_subframe(s[0], obs);
                pop_exp(exp);
                checks++;
                if (obs.v !== 1'b1 || obs !== exp) begin
                    $display("[TB] FAIL validity_f%0d_s%0d: got %h required %h", f, s, obs, exp);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_block_wrap();
        sub_t obs, exp;
        logic [191:0] cs_req;
        int bad;
        cs_req = '0;
`ifdef SPDIF_CHANNEL_STATUS_EN
        cs_req[2] = 1'b1;
        cs_req[26] = 1'b1;
        cs_req[27] = 1'b1;
`endif
        bad = 0;
        while (sb_frame != 0) begin
            data_left = $urandom;
            data_right = $urandom;
            validity = 1'($urandom_range(0, 1));
            push_frame();
            for (int s = 0; s < 2; s++) begin
                receive_subframe(s[0], obs);
                pop_exp(exp);
                if (obs !== exp) begin
                    if (bad < 5) $display("[TB] FAIL block_frame_%0d_s%0d: got %h required %h", rx_frame, s, obs, exp);
                    bad++;
                end
            end
        end
        checks++;
        if (bad != 0) begin
            $display("[TB] FAIL block_subframes: got %0d bad subframes required 0", bad);
            errors++;
        end
        checks++;
        if (cs_left !== cs_req || cs_right !== cs_req) begin
            $display("[TB] FAIL channel_status: got L %h R %h required %h", cs_left, cs_right, cs_req);
            errors++;
        end
        push_frame();
        receive_subframe(1'b0, obs);
        pop_exp(exp);
        checks++;
        if (obs.pre !== PRE_B || obs !== exp) begin
            $display("[TB] FAIL block_wrap_B: got %h required %h", obs, exp);
            errors++;
        end
        receive_subframe(1'b1, obs);
        pop_exp(exp);
    endtask

    task automatic test_reset_midframe();
        sub_t obs, exp;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (spdif_out !== 1'b0) begin
            $display("[TB] FAIL midframe_reset_immediate: got %b required 0", spdif_out);
            errors++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (spdif_out !== 1'b0) begin
                $display("[TB] FAIL midframe_reset_low: got %b required 0", spdif_out);
                errors++;
            end
        end
        sb.delete();
        sb_frame = 0;
        rx_frame = 0;
        data_left = 32'h13579B00;
        data_right = 32'h2468AC00;
        validity = 1'b0;
        push_frame();
        push_frame();
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            receive_subframe(s[0], obs);
            pop_exp(exp);
            checks++;
            if (obs !== exp) begin
                $display("[TB] FAIL restart_sub%0d: got %h required %h", s, obs, exp);
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_audio();
        test_frame_hold();
        test_validity();
        test_block_wrap();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spdif_transmit.md
SPDIF_TRANSMIT -- requirements
Module: spdif_transmit

Interface
REQ-001 SHALL have parameter SPDIF_BAUD, default 12_288_000, meaning S/PDIF bit rate in bits/s (64 bits per stereo frame).
REQ-002 SHALL have parameter CLK_FREQ, default 24_576_000, meaning clk frequency in Hz.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port data_left  input  32  left sample; bits [31:8] are the 24-bit audio word (MSB-aligned), bits [7:0] ignored.
REQ-006 SHALL have port data_right  input  32  right sample, same format as data_left.
REQ-007 SHALL have port validity  input  1  V flag sent in both subframes (0 = valid audio).
REQ-008 SHALL have port sample_rate_code  input  4  sample-rate field for channel status.
REQ-009 SHALL have port spdif_out  output  1  biphase-mark encoded, registered S/PDIF line.

Function
REQ-010 SHALL define half-cell period HALF = CLK_FREQ/(2*SPDIF_BAUD) clocks; HALF SHALL be an integer >= 1 (defaults give HALF = 1, so one half-cell per clock and 128 clocks per frame).
REQ-011 SHALL transmit continuous frames of two 32-slot subframes, left first, with no gaps.
REQ-012 Subframe slots SHALL be: 0-3 preamble, 4-27 audio bits [31:8] LSB first (slot 4 = bit 8), 28 V, 29 U (always 0), 30 C, 31 P.
REQ-013 P SHALL make slots 4-31 even parity, so each subframe ends at the same line level it started at.
REQ-014 data_left, data_right, validity and sample_rate_code SHALL be captured together in one clock at the start of each left subframe and held constant for the whole frame.
REQ-015 Data slots SHALL use biphase mark: a level toggle at every cell start, plus a mid-cell toggle for a 1.
REQ-016 Preambles SHALL be 8 half-cells: B = 11101000 (left subframe of frame 0 of the block), M = 11100010 (other left subframes), W = 11100100 (right); each pattern SHALL be inverted when the line level before the preamble is 1.
REQ-017 A frame counter SHALL count 0..191 and wrap to 0; frame 0 SHALL carry B.
REQ-018 Channel-status bit n of the block SHALL be sent in C of both subframes of frame n.
REQ-019 spdif_out SHALL change only on half-cell boundaries, with exactly one clock of latency from internal half-cell state to pin.

Reset
REQ-020 While rst = 1: spdif_out = 0, frame counter = 0, slot/half-cell/divider counters = 0, captured data = 0.
REQ-021 After rst falls, the first output SHALL be preamble B (non-inverted, since level = 0) of frame 0, starting on the first rising clk edge.
REQ-022 rst asserted mid-frame SHALL abort immediately and restart per REQ-021.

Configuration
REQ-023 With macro SPDIF_CHANNEL_STATUS_EN defined: channel status bits 0-1 = 0 (consumer, PCM audio), bit 2 = 1 (copy permitted), bits 24-27 = sample_rate_code[0..3] (bit 24+i = code[i]), all other bits 0.
REQ-024 Without SPDIF_CHANNEL_STATUS_EN: C SHALL be 0 in every subframe and sample_rate_code SHALL be ignored; all other behaviour is unchanged.

Verification
REQ-025 Assert rst for 10 clocks -> spdif_out = 0 throughout; after release, the first 8 half-cells are 11101000.
REQ-026 data_left = 32'h123456AB, data_right = 32'hFEDCBA00, validity = 0 -> decoded audio is 0x123456 (L) and 0xFEDCBA (R), V = 0, and parity is even in each subframe.
REQ-027 With default parameters -> preamble starts every 64 clocks (alternating M/W), and B recurs every 192*128 = 24576 clocks.
REQ-028 validity = 1 -> V = 1 in both subframes of every following frame.
REQ-029 sample_rate_code = 4'b1100 with SPDIF_CHANNEL_STATUS_EN -> decoded block C bits 2, 26 and 27 = 1, all others 0; without the macro -> all C bits = 0.
REQ-030 Assert rst for 3 clocks mid-frame -> spdif_out = 0 immediately; output restarts with B and frame counter = 0.
